mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles to wait for a memory ack before trapping (≥2).
REQ-002 SHALL have parameter TO_W, default 5, giving the timeout counter width; it SHALL satisfy 2^TO_W > TIMEOUT.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port instr, input, 32 bits: instruction register contents (opcode [6:0], funct3 [14:12], funct7 [31:25]).
REQ-006 SHALL have ports imem_req (output, 1 bit) and imem_ack (input, 1 bit): instruction fetch handshake.
REQ-007 SHALL have ports dmem_req (output, 1 bit) and dmem_ack (input, 1 bit): data access handshake.
REQ-008 SHALL have ports ir_we and pc_we, each output, 1 bit: instruction-register load strobe and PC update strobe.
REQ-009 SHALL have datapath control outputs npc_op [1:0], rf_wsel [1:0], ram_we, alu_op [3:0], alua_sel, alub_sel, sext_op [2:0], rf_we, with the same encodings the single-cycle core uses.
REQ-010 SHALL have port state_o, output, 3 bits: current state, for debug.
REQ-011 SHALL have port trap_o, output, 1 bit: sticky trap flag.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-013 FETCH: imem_req=1 until imem_ack; on ack, ir_we=1 for that cycle; next state DECODE.
REQ-014 DECODE: one cycle; legal opcode→EXEC; illegal opcode→TRAP.
REQ-015 EXEC: alu_op, alua_sel, alub_sel, sext_op valid; load/store→MEM; R/I/LUI/AUIPC/JAL/JALR→WB; branch→FETCH with pc_we=1.
REQ-016 MEM: dmem_req=1 until dmem_ack; ram_we=1 only while dmem_req=1 for a store; on ack, load→WB, store→FETCH with pc_we=1.
REQ-017 WB: rf_we=1 and pc_we=1 for exactly one cycle; next state FETCH.
REQ-018 rf_we, ram_we, pc_we and ir_we SHALL never be asserted outside the states named above.
REQ-019 Zero-wait latency SHALL be: ALU 4 cycles, load 5, store 4, branch 3, JAL/JALR 4.
REQ-020 The timeout counter SHALL clear on entry to FETCH or MEM and increment each cycle the req is unacked; reaching TIMEOUT→TRAP.
REQ-021 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (normal transition, no trap).
REQ-022 TRAP SHALL be absorbing: all strobes 0, req outputs 0, trap_o=1; exit only by reset.
REQ-023 An ack received while the matching req=0 SHALL be ignored.
REQ-024 The decoded control fields SHALL be held stable from DECODE through the final state of the instruction.

Reset
REQ-025 rst_n low SHALL asynchronously force state FETCH, counter 0, trap_o 0, and all strobes and req outputs 0.
REQ-026 imem_req SHALL rise on the first clock after rst_n deasserts.
REQ-027 Reset asserted mid-access SHALL drop req immediately, and the in-flight instruction SHALL be abandoned.

Configuration
REQ-028 Macro MC_CTRL_MEXT_EN SHALL, when defined, add outputs mdu_start, alu_sel_mdu and input mdu_done.
REQ-029 With MC_CTRL_MEXT_EN defined: an R-type instruction with funct7=0000001 in EXEC SHALL pulse mdu_start for 1 cycle, hold EXEC until mdu_done, then go to WB with alu_sel_mdu=1; EXEC has no timeout for this wait.
REQ-030 With MC_CTRL_MEXT_EN undefined: funct7=0000001 on R-type SHALL be illegal→TRAP, and the ports SHALL be absent.

Structure
REQ-031 The shared package mc_pkg SHALL hold the state enum, opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP), the npc_op/rf_wsel/sext_op encodings and the TIMEOUT default.
REQ-032 The combinational field decode SHALL live in sub-module ctrl_decode (inputs opcode/funct3/funct7, outputs control fields plus legal); mc_controller owns the FSM, counter and strobes.

Verification
REQ-033 add x1,x2,x3 with imem_ack 1 cycle after req → states 0,1,2,4,0; rf_we and pc_we high only in the WB cycle.
REQ-034 lw with dmem_ack delayed 3 cycles → dmem_req high 4 cycles, ram_we=0, rf_we in WB; 8 cycles total.
REQ-035 sw with zero-wait ack → ram_we=1 for 1 cycle in MEM, rf_we never 1; 4 cycles total.
REQ-036 imem_ack never asserted, TIMEOUT=16 → TRAP after 16 cycles of FETCH; trap_o=1 held; imem_req=0.
REQ-037 ack coincident with the count reaching TIMEOUT → no trap; also opcode 0000000 → TRAP from DECODE.
REQ-038 rst_n pulsed low mid-MEM → dmem_req=0 asynchronously; after release FETCH with imem_req=1; MUL with mdu_done after 5 cycles (macro on) → mdu_start for 1 cycle, then WB.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM states,
// opcodes, datapath select encodings and the decoded control bundle.
package mc_pkg;

    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned TO_W_DEF    = 5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JAL  = 2'd2;
    localparam logic [1:0] NPC_JALR = 2'd3;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_SEXT = 2'd1;
    localparam logic [1:0] WSEL_PC4  = 2'd2;
    localparam logic [1:0] WSEL_RAM  = 2'd3;

    localparam logic [2:0] SEXT_I = 3'd0;
    localparam logic [2:0] SEXT_S = 3'd1;
    localparam logic [2:0] SEXT_B = 3'd2;
    localparam logic [2:0] SEXT_U = 3'd3;
    localparam logic [2:0] SEXT_J = 3'd4;

    localparam logic ALUA_RS1 = 1'b0;
    localparam logic ALUA_PC  = 1'b1;
    localparam logic ALUB_RS2 = 1'b0;
    localparam logic ALUB_IMM = 1'b1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_BEQ  = 4'd10;
    localparam logic [3:0] ALU_BNE  = 4'd11;
    localparam logic [3:0] ALU_BLT  = 4'd12;
    localparam logic [3:0] ALU_BGE  = 4'd13;
    localparam logic [3:0] ALU_BLTU = 4'd14;
    localparam logic [3:0] ALU_BGEU = 4'd15;

    // Which path the FSM takes after EXEC
    typedef enum logic [1:0] {
        K_REG    = 2'd0,
        K_LOAD   = 2'd1,
        K_STORE  = 2'd2,
        K_BRANCH = 2'd3
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic       mdu;
        logic [1:0] npc_op;
        logic [1:0] rf_wsel;
        logic [3:0] alu_op;
        logic       alua_sel;
        logic       alub_sel;
        logic [2:0] sext_op;
    } ctrl_t;

    function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] br_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_BEQ;
            3'b001:  return ALU_BNE;
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            default: return ALU_BGEU;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction field decode into the control bundle plus a
// legality flag. MC_CTRL_MEXT_EN makes funct7=0000001 R-type legal (MDU op).
module ctrl_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl,
    output logic       legal
);

    always_comb begin
        ctrl  = '0;
        legal = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal        = 1'b1;
                ctrl.rf_wsel = WSEL_SEXT;
                ctrl.sext_op = SEXT_U;
            end
            OPC_AUIPC: begin
                legal         = 1'b1;
                ctrl.alua_sel = ALUA_PC;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op  = SEXT_U;
            end
            OPC_JAL: begin
                legal        = 1'b1;
                ctrl.npc_op  = NPC_JAL;
                ctrl.rf_wsel = WSEL_PC4;
                ctrl.sext_op = SEXT_J;
            end
            OPC_JALR: begin
                legal         = (funct3 == 3'b000);
                ctrl.npc_op   = NPC_JALR;
                ctrl.rf_wsel  = WSEL_PC4;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op  = SEXT_I;
            end
            OPC_BRANCH: begin
                legal        = (funct3[2:1] != 2'b01);
                ctrl.kind    = K_BRANCH;
                ctrl.npc_op  = NPC_BR;
                ctrl.alu_op  = br_f3(funct3);
                ctrl.sext_op = SEXT_B;
            end
            OPC_LOAD: begin
                legal         = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                ctrl.kind     = K_LOAD;
                ctrl.rf_wsel  = WSEL_RAM;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op  = SEXT_I;
            end
            OPC_STORE: begin
                legal         = funct3 inside {3'b000, 3'b001, 3'b010};
                ctrl.kind     = K_STORE;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op  = SEXT_S;
            end
            OPC_OPIMM: begin
                // Only the shift forms constrain funct7
                if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
                else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                else                       legal = 1'b1;
                ctrl.alu_op   = alu_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op  = SEXT_I;
            end
            OPC_OP: begin
                ctrl.alu_op = alu_f3(funct3, funct7[5]);
                if (funct7 == 7'b0000000)      legal = 1'b1;
                else if (funct7 == 7'b0100000) legal = (funct3 == 3'b000) || (funct3 == 3'b101);
`ifdef MC_CTRL_MEXT_EN
                else if (funct7 == 7'b0000001) begin
                    legal    = 1'b1;
                    ctrl.mdu = 1'b1;
                end
`endif
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle core controller: FETCH/DECODE/EXEC/MEM/WB FSM with ack timeout
// trap. Define MC_CTRL_MEXT_EN to add the multiply/divide unit handshake.
module mc_controller
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TO_W    = TO_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_op,
    output logic [1:0]  rf_wsel,
    output logic        ram_we,
    output logic [3:0]  alu_op,
    output logic        alua_sel,
    output logic        alub_sel,
    output logic [2:0]  sext_op,
    output logic        rf_we,
    output logic [2:0]  state_o,
    output logic        trap_o
`ifdef MC_CTRL_MEXT_EN
    ,
    output logic        mdu_start,
    output logic        alu_sel_mdu,
    input  logic        mdu_done
`endif
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state, next_state;
    logic [TO_W-1:0] cnt, cnt_d;
    ctrl_t           ctrl_c, ctrl_q, ctrl;
    logic            legal;
    logic            mdu_op, mdu_done_i, mdu_go, mdu_busy;
    logic            unused_instr;

    ctrl_decode u_decode (
        .opcode (instr[6:0]),
        .funct3 (instr[14:12]),
        .funct7 (instr[31:25]),
        .ctrl   (ctrl_c),
        .legal  (legal)
    );

    assign unused_instr = ^{instr[24:15], instr[11:7]};

`ifdef MC_CTRL_MEXT_EN
    assign mdu_op      = ctrl.mdu;
    assign mdu_done_i  = mdu_done;
    assign mdu_start   = mdu_go;
    assign alu_sel_mdu = ctrl.mdu;
`else
    logic unused_mdu;
    assign mdu_op     = 1'b0;
    assign mdu_done_i = 1'b0;
    assign unused_mdu = ctrl.mdu;
`endif

    // Fields come straight from decode in DECODE, then from the snapshot
    assign ctrl     = (state == S_DECODE) ? ctrl_c : ctrl_q;
    assign npc_op   = ctrl.npc_op;
    assign rf_wsel  = ctrl.rf_wsel;
    assign alu_op   = ctrl.alu_op;
    assign alua_sel = ctrl.alua_sel;
    assign alub_sel = ctrl.alub_sel;
    assign sext_op  = ctrl.sext_op;
    assign ram_we   = dmem_req && (ctrl.kind == K_STORE);
    assign state_o  = state;
    assign trap_o   = (state == S_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            cnt      <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            ctrl_q   <= '0;
            mdu_busy <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= cnt_d;
            imem_req <= (next_state == S_FETCH);
            dmem_req <= (next_state == S_MEM);
            mdu_busy <= (next_state == S_EXEC) && (mdu_busy || mdu_go);
            if (state == S_DECODE) ctrl_q <= ctrl_c;
        end
    end

    // Next state, timeout count and handshake-qualified strobes
    always_comb begin
        next_state = state;
        cnt_d      = cnt;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        mdu_go     = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_req) begin
                    if (imem_ack) begin
                        ir_we      = 1'b1;
                        next_state = S_DECODE;
                    end else if (cnt == TO_LAST) begin
                        next_state = S_TRAP;
                    end else begin
                        cnt_d = cnt + TO_W'(1);
                    end
                end
            end
            S_DECODE: next_state = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (mdu_op) begin
                    if (!mdu_busy)      mdu_go     = 1'b1;
                    else if (mdu_done_i) next_state = S_WB;
                end else begin
                    case (ctrl.kind)
                        K_LOAD, K_STORE: next_state = S_MEM;
                        K_BRANCH: begin
                            pc_we      = 1'b1;
                            next_state = S_FETCH;
                        end
                        default: next_state = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                if (dmem_req) begin
                    if (dmem_ack) begin
                        if (ctrl.kind == K_STORE) begin
                            pc_we      = 1'b1;
                            next_state = S_FETCH;
                        end else begin
                            next_state = S_WB;
                        end
                    end else if (cnt == TO_LAST) begin
                        next_state = S_TRAP;
                    end else begin
                        cnt_d = cnt + TO_W'(1);
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_TRAP;
        endcase
        if (next_state != state) cnt_d = '0;
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller; expected per-cycle strobes are
// queued before each step and compared mid-cycle.
module tb_mc_controller;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        imem_req, imem_ack, dmem_req, dmem_ack;
    logic        ir_we, pc_we, ram_we, rf_we;
    logic [1:0]  npc_op, rf_wsel;
    logic [3:0]  alu_op;
    logic        alua_sel, alub_sel;
    logic [2:0]  sext_op;
    logic [2:0]  state_o;
    logic        trap_o;
`ifdef MC_CTRL_MEXT_EN
    logic        mdu_start, alu_sel_mdu, mdu_done;
`endif

    mc_controller #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .dmem_req (dmem_req),
        .dmem_ack (dmem_ack),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .npc_op   (npc_op),
        .rf_wsel  (rf_wsel),
        .ram_we   (ram_we),
        .alu_op   (alu_op),
        .alua_sel (alua_sel),
        .alub_sel (alub_sel),
        .sext_op  (sext_op),
        .rf_we    (rf_we),
        .state_o  (state_o),
        .trap_o   (trap_o)
`ifdef MC_CTRL_MEXT_EN
        ,
        .mdu_start   (mdu_start),
        .alu_sel_mdu (alu_sel_mdu),
        .mdu_done    (mdu_done)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {state, imem_req, dmem_req, ir_we, pc_we, rf_we, ram_we, trap_o}
    localparam logic [9:0] E_RST = {3'd0, 7'b0000000};
    localparam logic [9:0] E_F0  = {3'd0, 7'b1000000};
    localparam logic [9:0] E_FA  = {3'd0, 7'b1010000};
    localparam logic [9:0] E_D   = {3'd1, 7'b0000000};
    localparam logic [9:0] E_E   = {3'd2, 7'b0000000};
    localparam logic [9:0] E_EB  = {3'd2, 7'b0001000};
    localparam logic [9:0] E_M   = {3'd3, 7'b0100000};
    localparam logic [9:0] E_MS  = {3'd3, 7'b0101010};
    localparam logic [9:0] E_WB  = {3'd4, 7'b0001100};
    localparam logic [9:0] E_T   = {3'd5, 7'b0000001};

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_SUB = 32'h403100B3;
    localparam logic [31:0] I_LW  = 32'h00812283;
    localparam logic [31:0] I_SW  = 32'h00512223;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_JAL = 32'h010000EF;
    localparam logic [31:0] I_MUL = 32'h023100B3;

    logic [9:0]  obs;
    logic [12:0] fld;
    assign obs = {state_o, imem_req, dmem_req, ir_we, pc_we, rf_we, ram_we, trap_o};
    assign fld = {alu_op, npc_op, rf_wsel, alua_sel, alub_sel, sext_op};

    typedef struct {
        string       tag;
        logic [9:0]  e;
        logic        fchk;
        logic [12:0] f;
        logic [1:0]  m;
    } item_t;

    item_t sb_q[$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [12:0] fv(input int alu, input int npc, input int wsel,
                                       input int a, input int b, input int sx);
        return {4'(alu), 2'(npc), 2'(wsel), 1'(a), 1'(b), 3'(sx)};
    endfunction

    task automatic plan_full(input string tag, input logic [9:0] e, input logic fchk,
                             input logic [12:0] f, input logic [1:0] m);
        item_t it;
        it.tag  = tag;
        it.e    = e;
        it.fchk = fchk;
        it.f    = f;
        it.m    = m;
        sb_q.push_back(it);
    endtask

    task automatic plan(input string tag, input logic [9:0] e);
        plan_full(tag, e, 1'b0, 13'd0, 2'b00);
    endtask

    task automatic planf(input string tag, input logic [9:0] e, input logic [12:0] f);
        plan_full(tag, e, 1'b1, f, 2'b00);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive acks for one cycle, compare mid-cycle, advance to just past the edge
    task automatic step(input logic ia, input logic da);
        item_t it;
        imem_ack = ia;
        dmem_ack = da;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_empty: observed %b with no expectation queued", obs);
        end else begin
            it = sb_q.pop_front();
            vectors++;
            assert (obs === it.e) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b", it.tag, obs, it.e);
            end
            if (it.fchk) begin
                vectors++;
                assert (fld === it.f) else begin
                    miscompares++;
                    $error("FAIL %s_fields: observed %h expected %h", it.tag, fld, it.f);
                end
            end
`ifdef MC_CTRL_MEXT_EN
            vectors++;
            assert ({mdu_start, alu_sel_mdu} === it.m) else begin
                miscompares++;
                $error("FAIL %s_mdu: observed %b expected %b", it.tag, {mdu_start, alu_sel_mdu}, it.m);
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        plan("rst_exit", E_RST);
        step(1'b1, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        instr    = 32'h0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
`ifdef MC_CTRL_MEXT_EN
        mdu_done = 1'b0;
`endif
        @(negedge clk);
        chk("reset_state", 32'(obs), 32'(E_RST));
        release_reset();

        // add: ack one cycle after req, F D E WB
        instr = I_ADD;
        plan("add_f0", E_F0);  step(1'b0, 1'b0);
        plan("add_fa", E_FA);  step(1'b1, 1'b0);
        plan("add_d", E_D);    step(1'b1, 1'b1);
        planf("add_e", E_E, fv(0, 0, 0, 0, 0, 0)); step(1'b0, 1'b0);
        plan("add_wb", E_WB);  step(1'b0, 1'b0);

        // lw with dmem_ack three cycles late
        instr = I_LW;
        plan("lw_fa", E_FA);   step(1'b1, 1'b0);
        plan("lw_d", E_D);     step(1'b0, 1'b0);
        plan("lw_e", E_E);     step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            plan("lw_mwait", E_M); step(1'b0, 1'b0);
        end
        planf("lw_mack", E_M, fv(0, 0, 3, 0, 1, 0)); step(1'b0, 1'b1);
        plan("lw_wb", E_WB);   step(1'b0, 1'b0);

        // sw zero-wait
        instr = I_SW;
        plan("sw_fa", E_FA);   step(1'b1, 1'b0);
        plan("sw_d", E_D);     step(1'b0, 1'b0);
        plan("sw_e", E_E);     step(1'b0, 1'b0);
        plan("sw_m", E_MS);    step(1'b0, 1'b1);

        // beq: three cycles, pc_we in EXEC
        instr = I_BEQ;
        plan("beq_fa", E_FA);  step(1'b1, 1'b0);
        plan("beq_d", E_D);    step(1'b0, 1'b0);
        planf("beq_e", E_EB, fv(10, 1, 0, 0, 0, 2)); step(1'b0, 1'b0);

        // jal: fields must survive the IR changing after DECODE
        instr = I_JAL;
        plan("jal_fa", E_FA);  step(1'b1, 1'b0);
        plan("jal_d", E_D);    step(1'b0, 1'b0);
        instr = 32'hFFFF_FFFF;
        plan("jal_e", E_E);    step(1'b0, 1'b0);
        planf("jal_wb", E_WB, fv(0, 2, 2, 0, 0, 4)); step(1'b0, 1'b0);

        instr = I_SUB;
        plan("sub_fa", E_FA);  step(1'b1, 1'b0);
        plan("sub_d", E_D);    step(1'b0, 1'b0);
        planf("sub_e", E_E, fv(1, 0, 0, 0, 0, 0)); step(1'b0, 1'b0);
        plan("sub_wb", E_WB);  step(1'b0, 1'b0);

        // ack on the last permitted cycle wins over the timeout
        instr = I_ADD;
        for (int i = 0; i < 15; i++) begin
            plan("edge_wait", E_F0); step(1'b0, 1'b0);
        end
        plan("edge_fa", E_FA); step(1'b1, 1'b0);
        plan("edge_d", E_D);   step(1'b0, 1'b0);
        plan("edge_e", E_E);   step(1'b0, 1'b0);
        plan("edge_wb", E_WB); step(1'b0, 1'b0);

        // illegal opcode traps from DECODE; acks in TRAP are ignored
        instr = 32'h0;
        plan("ill_fa", E_FA);  step(1'b1, 1'b0);
        plan("ill_d", E_D);    step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            plan("ill_trap", E_T); step(1'b1, 1'b1);
        end

        rst_n = 1'b0;
        #1;
        chk("trap_reset", 32'(obs), 32'(E_RST));
        release_reset();

        // imem never acks: 16 cycles of req, then absorbing TRAP
        for (int i = 0; i < 16; i++) begin
            plan("to_wait", E_F0); step(1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            plan("to_trap", E_T); step(1'b1, 1'b0);
        end

        rst_n = 1'b0;
        #1;
        chk("to_reset", 32'(obs), 32'(E_RST));
        release_reset();

        // reset in the middle of a data access
        instr = I_LW;
        plan("rm_fa", E_FA);   step(1'b1, 1'b0);
        plan("rm_d", E_D);     step(1'b0, 1'b0);
        plan("rm_e", E_E);     step(1'b0, 1'b0);
        plan("rm_m0", E_M);    step(1'b0, 1'b0);
        plan("rm_m1", E_M);    step(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_dmem_req", 32'(dmem_req), 32'd0);
        chk("rm_state", 32'(state_o), 32'd0);
        release_reset();
        plan("rm_refetch", E_F0); step(1'b0, 1'b0);

        instr = I_MUL;
        plan("mul_fa", E_FA);  step(1'b1, 1'b0);
`ifdef MC_CTRL_MEXT_EN
        plan_full("mul_d", E_D, 1'b0, 13'd0, 2'b01);      step(1'b0, 1'b0);
        plan_full("mul_start", E_E, 1'b0, 13'd0, 2'b11);  step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            plan_full("mul_wait", E_E, 1'b0, 13'd0, 2'b01); step(1'b0, 1'b0);
        end
        mdu_done = 1'b1;
        plan_full("mul_done", E_E, 1'b0, 13'd0, 2'b01);   step(1'b0, 1'b0);
        mdu_done = 1'b0;
        plan_full("mul_wb", E_WB, 1'b0, 13'd0, 2'b01);    step(1'b0, 1'b0);
`else
        plan("mul_d", E_D);    step(1'b0, 1'b0);
        plan("mul_trap", E_T); step(1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
